ghost_mover: RTL

- Per-ghost movement controller; four instances (red, pink, blue, yellow) drive the x_*/y_* position inputs of the enemy sprite renderer.
- On each frame tick, advances the ghost's pixel position by STEP pixels.
- At every 8x8 tile centre it picks the next direction: arcade rules, maze-wall lookups, nearest-to-target tile.
- Target tile is supplied by the AI/mode logic; no reverse unless at a dead end; horizontal tunnel wraps.

---
 rtl/ghost_mover.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ghost_mover.sv
// Per-ghost movement controller: steps the sprite each frame tick and, at tile
// centres, picks the open neighbour tile closest to the target (arcade rules).
module ghost_mover #(
  parameter logic [8:0]  START_X      = 9'd112,
  parameter logic [8:0]  START_Y      = 9'd112,
  parameter logic [1:0]  START_DIR    = 2'd1,
  parameter int unsigned STEP         = 1,
  parameter int unsigned MAZE_W_TILES = 28,
  parameter int unsigned MAZE_H_TILES = 36
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic [4:0] target_tx,
  input  logic [5:0] target_ty,
  output logic       wall_rd,
  output logic [9:0] wall_addr,
  input  logic       wall_data,
  output logic [8:0] x,
  output logic [8:0] y,
  output logic [1:0] dir,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, CHECK, EVAL_REQ, EVAL_RSP, MOVE} state_t;

  localparam logic [9:0] XW  = 10'(MAZE_W_TILES * 8);
  localparam logic [9:0] STP = 10'(STEP);

  state_t      state_q;
  logic [8:0]  x_q, y_q;
  logic [1:0]  dir_q, next_dir_q;
  logic        wall_rd_q;
  logic [9:0]  wall_addr_q;
  logic [1:0]  c_q;
  logic        issued_q;
  logic [11:0] dist_q, best_q;
  logic        found_q;
  logic [1:0]  best_dir_q;

  logic              aligned;
  logic [1:0]        cand;
  logic [5:0]        tx, ty;
  logic [5:0]        nb_x;
  logic signed [7:0] nb_y;
  logic              row_ok, rd_ok;
  logic signed [6:0] dx, dy;
  logic signed [13:0] dxw, dyw;
  logic [11:0]       nb_dist;
  logic [9:0]        nb_addr;
  logic              take, win_found;
  logic [1:0]        win_dir;

  assign aligned = (x_q[2:0] == 3'd0) && (y_q[2:0] == 3'd0);
  assign tx      = x_q[8:3];
  assign ty      = y_q[8:3];
  // Neighbour logic is shared: it always describes the candidate about to be requested.
  assign cand    = (state_q == CHECK) ? 2'd0 : c_q + 2'd1;

  always_comb begin
    nb_x = tx;
    nb_y = $signed({2'b00, ty});
    case (cand)
      2'd0: nb_y = nb_y - 8'sd1;
      2'd1: nb_x = (tx == 6'd0) ? 6'(MAZE_W_TILES - 1) : tx - 6'd1;
      2'd2: nb_y = nb_y + 8'sd1;
      default: nb_x = (tx == 6'(MAZE_W_TILES - 1)) ? 6'd0 : tx + 6'd1;
    endcase
    row_ok  = !nb_y[7] && (nb_y[6:0] < 7'(MAZE_H_TILES));
    rd_ok   = row_ok && (cand != (dir_q ^ 2'd2));
    dx      = {1'b0, nb_x} - {2'b00, target_tx};
    dy      = nb_y[6:0] - {1'b0, target_ty};
    dxw     = 14'(dx);
    dyw     = 14'(dy);
    nb_dist = 12'(dxw * dxw + dyw * dyw);
    nb_addr = 10'(nb_y[5:0]) * 10'(MAZE_W_TILES) + 10'(nb_x);
  end

  always_comb begin
    take      = issued_q && !wall_data && (!found_q || (dist_q < best_q));
    win_found = found_q || take;
    win_dir   = take ? c_q : best_dir_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      x_q         <= START_X;
      y_q         <= START_Y;
      dir_q       <= START_DIR;
      next_dir_q  <= START_DIR;
      wall_rd_q   <= 1'b0;
      wall_addr_q <= '0;
      c_q         <= '0;
      issued_q    <= 1'b0;
      dist_q      <= '0;
      best_q      <= '1;
      found_q     <= 1'b0;
      best_dir_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (frame_tick && enable) state_q <= CHECK;
        CHECK: begin
          if (aligned) begin
            found_q    <= 1'b0;
            best_q     <= '1;
            best_dir_q <= dir_q;
            c_q        <= cand;
            wall_rd_q  <= rd_ok;
            if (rd_ok) wall_addr_q <= nb_addr;
            dist_q     <= nb_dist;
            state_q    <= EVAL_REQ;
          end else begin
            next_dir_q <= dir_q;
            state_q    <= MOVE;
          end
        end
        EVAL_REQ: begin
          issued_q  <= wall_rd_q;
          wall_rd_q <= 1'b0;
          state_q   <= EVAL_RSP;
        end
        EVAL_RSP: begin
          found_q    <= win_found;
          best_dir_q <= win_dir;
          if (take) best_q <= dist_q;
          if (c_q == 2'd3) begin
            next_dir_q <= win_found ? win_dir : (dir_q ^ 2'd2);
            state_q    <= MOVE;
          end else begin
            c_q       <= cand;
            wall_rd_q <= rd_ok;
            if (rd_ok) wall_addr_q <= nb_addr;
            dist_q    <= nb_dist;
            state_q   <= EVAL_REQ;
          end
        end
        MOVE: begin
          dir_q <= next_dir_q;
          case (next_dir_q)
            2'd0: y_q <= y_q - 9'(STEP);
            2'd2: y_q <= y_q + 9'(STEP);
            2'd1: begin
              if ({1'b0, x_q} < STP) x_q <= 9'(XW - STP + {1'b0, x_q});
              else                   x_q <= x_q - 9'(STEP);
            end
            default: begin
              if ({1'b0, x_q} + STP >= XW) x_q <= 9'({1'b0, x_q} + STP - XW);
              else                         x_q <= x_q + 9'(STEP);
            end
          endcase
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wall_rd   = wall_rd_q;
  assign wall_addr = wall_addr_q;
  assign x         = x_q;
  assign y         = y_q;
  assign dir       = dir_q;
  assign busy      = (state_q != IDLE);

endmodule
